// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types and helpers for the push-button conditioner.
//   btn_state_t : per-channel classification state (IDLE, PRESSED, LONG)
//   cnt_width() : bits needed to hold a counter value 0..max_val
//   DEF_*       : defaults for the 100 MHz board (100 Hz sample tick, 2 s long press)
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  localparam int unsigned DEF_SAMPLE_DIV   = 1000000;
  localparam int unsigned DEF_DEB_SAMPLES  = 4;
  localparam int unsigned DEF_LONG_TICKS   = 200;
  localparam int unsigned DEF_REPEAT_TICKS = 25;

  // Width of a counter that must represent 0..max_val (never less than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// -----------------------------------------------------------------------------
// btn_channel
// One button channel: 2-FF synchroniser, sample-tick debouncer, and the
// tap / long-press classifier with registered one-clk pulses.
// Optional build macro: BTN_AUTO_REPEAT_EN (repeat press_pulse while in LONG).
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   tick           shared debounce sample strobe (one clk wide)
//   btn_raw        raw asynchronous button input
//   level          debounced pressed level (1 = pressed)
//   press_pulse    one clk on press (and on each auto-repeat when enabled)
//   release_pulse  one clk on release
//   tap_pulse      one clk on release before the long threshold
//   long_pulse     one clk when the hold reaches LONG_TICKS
//   held_long      high from long_pulse until release
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | released, waiting for the debounced level to rise
// PRESSED | held, counting ticks toward the long-press threshold
// LONG    | held past the threshold, waiting for release
// -----------------------------------------------------------------------------
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEB_SAMPLES  = DEF_DEB_SAMPLES,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic tap_pulse,
  output logic long_pulse,
  output logic held_long
);

  localparam int unsigned       HOLD_W   = cnt_width(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

  logic                   sync_q1;
  logic                   sync_q2;
  logic                   pressed_in;
  logic [DEB_SAMPLES-1:0] samples;
  logic [DEB_SAMPLES-1:0] samples_next;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   rep_fire;

  btn_state_t state;
  btn_state_t state_next;
  logic       press_next;
  logic       release_next;
  logic       tap_next;
  logic       long_next;
  logic       held_next;

  // Synchroniser resets to the released raw value so an active-low input
  // does not look pressed straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= ACTIVE_LOW;
      sync_q2 <= ACTIVE_LOW;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign pressed_in   = sync_q2 ^ ACTIVE_LOW;
  assign samples_next = {samples[DEB_SAMPLES-2:0], pressed_in};

  // Level follows only a full window of agreeing samples, including the one
  // being shifted in on this tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samples <= '0;
      level   <= 1'b0;
    end else if (tick) begin
      samples <= samples_next;
      if (&samples_next) begin
        level <= 1'b1;
      end else if (~|samples_next) begin
        level <= 1'b0;
      end
    end
  end

  // Saturating hold counter; cleared whenever the channel is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (tick && level && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned      REP_W   = cnt_width(REPEAT_TICKS);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_TICKS);

  logic [REP_W-1:0] rep_cnt;

  // Zero outside LONG so it starts fresh on every entry; restarts after each repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if ((state != LONG) || rep_fire) begin
      rep_cnt <= '0;
    end else if (tick && level && (rep_cnt != REP_MAX)) begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  // Gated by level so a repeat landing on the release tick is dropped.
  assign rep_fire = (state == LONG) && level && (rep_cnt == REP_MAX);
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_TICKS;
  assign rep_fire      = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    press_next   = 1'b0;
    release_next = 1'b0;
    tap_next     = 1'b0;
    long_next    = 1'b0;
    case (state)
      IDLE: begin
        if (level) begin
          state_next = PRESSED;
          press_next = 1'b1;
        end
      end
      PRESSED: begin
        // Release is checked first so a fall on the threshold tick is a tap.
        if (!level) begin
          state_next   = IDLE;
          release_next = 1'b1;
          tap_next     = 1'b1;
        end else if (hold_cnt == HOLD_MAX) begin
          state_next = LONG;
          long_next  = 1'b1;
        end
      end
      LONG: begin
        if (!level) begin
          state_next   = IDLE;
          release_next = 1'b1;
        end else if (rep_fire) begin
          press_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    held_next = (state_next == LONG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      tap_pulse     <= 1'b0;
      long_pulse    <= 1'b0;
      held_long     <= 1'b0;
    end else begin
      state         <= state_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      tap_pulse     <= tap_next;
      long_pulse    <= long_next;
      held_long     <= held_next;
    end
  end

endmodule

// File: rtl/btn_conditioner_multi.sv
// -----------------------------------------------------------------------------
// btn_conditioner_multi
// N-channel push-button conditioner: one shared sample-tick divider feeding
// NUM_CH independent btn_channel instances.
// Optional build macro: BTN_AUTO_REPEAT_EN (auto-repeat press_pulse in LONG).
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   btn_in         raw asynchronous button inputs [NUM_CH]
//   level          debounced pressed level, 1 = pressed [NUM_CH]
//   press_pulse    one-clk press pulse [NUM_CH]
//   release_pulse  one-clk release pulse [NUM_CH]
//   tap_pulse      one-clk short-press pulse on release [NUM_CH]
//   long_pulse     one-clk pulse when hold reaches LONG_TICKS [NUM_CH]
//   held_long      high from long_pulse until release [NUM_CH]
// -----------------------------------------------------------------------------
module btn_conditioner_multi
  import btn_pkg::*;
#(
  parameter int unsigned       NUM_CH          = 4,
  parameter int unsigned       SAMPLE_DIV      = DEF_SAMPLE_DIV,
  parameter int unsigned       DEB_SAMPLES     = DEF_DEB_SAMPLES,
  parameter int unsigned       LONG_TICKS      = DEF_LONG_TICKS,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = '0,
  parameter int unsigned       REPEAT_TICKS    = DEF_REPEAT_TICKS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] tap_pulse,
  output logic [NUM_CH-1:0] long_pulse,
  output logic [NUM_CH-1:0] held_long
);

  localparam int unsigned DIV_W = cnt_width(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    btn_channel #(
      .DEB_SAMPLES  (DEB_SAMPLES),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .ACTIVE_LOW   (ACTIVE_LOW_MASK[i])
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .btn_raw       (btn_in[i]),
      .level         (level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .tap_pulse     (tap_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .held_long     (held_long[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner_multi.sv
`timescale 1ns/1ps
module tb_btn_conditioner_multi;

  localparam int         NUM_CH = 4;
  localparam int         DIV    = 4;
  localparam int         DEB    = 3;
  localparam int         LONG_T = 5;
  localparam int         REP_T  = 2;
  localparam logic [3:0] MASK   = 4'b1000;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AUTO_REP = 1'b1;
`else
  localparam bit AUTO_REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_in = MASK;
  logic [3:0] level, press_pulse, release_pulse, tap_pulse, long_pulse, held_long;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  btn_conditioner_multi #(
    .NUM_CH          (NUM_CH),
    .SAMPLE_DIV      (DIV),
    .DEB_SAMPLES     (DEB),
    .LONG_TICKS      (LONG_T),
    .ACTIVE_LOW_MASK (MASK),
    .REPEAT_TICKS    (REP_T)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .tap_pulse     (tap_pulse),
    .long_pulse    (long_pulse),
    .held_long     (held_long)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: debounce as a run length of agreeing samples, press
  // classification from the number of ticks held since the press.
  logic [3:0] m_s1 = MASK, m_s2 = MASK;
  int         m_cnt = 0;
  bit         m_tk, m_smp, m_old;
  bit         m_last [4];
  int         m_run  [4] = '{DEB, DEB, DEB, DEB};
  bit         m_lvl  [4];
  int         m_k    [4];
  bit         ev_press [4], ev_rel [4], ev_tap [4], ev_long [4], ev_held [4];
  logic [3:0] e_level = '0, e_press = '0, e_rel = '0, e_tap = '0, e_long = '0, e_held = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = MASK; m_s2 = MASK; m_cnt = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_last[i] = 1'b0; m_run[i] = DEB; m_lvl[i] = 1'b0; m_k[i] = 0;
        ev_press[i] = 0; ev_rel[i] = 0; ev_tap[i] = 0; ev_long[i] = 0; ev_held[i] = 0;
      end
      e_level = '0; e_press = '0; e_rel = '0; e_tap = '0; e_long = '0; e_held = '0;
    end else begin
      m_tk  = (m_cnt == DIV - 1);
      m_cnt = m_tk ? 0 : m_cnt + 1;
      for (int i = 0; i < NUM_CH; i++) begin
        // pulses are the events found one clk earlier
        e_press[i] = ev_press[i]; e_rel[i] = ev_rel[i]; e_tap[i] = ev_tap[i];
        e_long[i]  = ev_long[i];  e_held[i] = ev_held[i];
        ev_press[i] = 0; ev_rel[i] = 0; ev_tap[i] = 0; ev_long[i] = 0;
        m_smp = m_s2[i] ^ MASK[i];
        m_old = m_lvl[i];
        if (m_tk) begin
          if (m_smp == m_last[i]) m_run[i] = (m_run[i] < DEB) ? m_run[i] + 1 : DEB;
          else begin m_last[i] = m_smp; m_run[i] = 1; end
          if (m_run[i] >= DEB) m_lvl[i] = m_last[i];
          if (m_old) m_k[i]++;
          if (!m_old && m_lvl[i]) begin
            m_k[i] = 0; ev_press[i] = 1;
          end else if (m_old && !m_lvl[i]) begin
            ev_rel[i] = 1; ev_tap[i] = (m_k[i] <= LONG_T);
          end else if (m_old && m_lvl[i]) begin
            if (m_k[i] == LONG_T) ev_long[i] = 1;
            if (AUTO_REP && m_k[i] > LONG_T && ((m_k[i] - LONG_T) % REP_T) == 0) ev_press[i] = 1;
          end
        end
        ev_held[i] = m_lvl[i] && (m_k[i] >= LONG_T);
        e_level[i] = m_lvl[i];
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
  end

  always @(negedge clk) begin
    chk("level", level, e_level);
    chk("press_pulse", press_pulse, e_press);
    chk("release_pulse", release_pulse, e_rel);
    chk("tap_pulse", tap_pulse, e_tap);
    chk("long_pulse", long_pulse, e_long);
    chk("held_long", held_long, e_held);
  end

  // Event counters for the hand-computed expectations.
  int n_press [4], n_rel [4], n_tap [4], n_long [4], n_held [4], n_lvl [4];
  int c_press [4], c_rel [4], c_tap [4], c_long [4];
  int b_press [4], b_rel [4], b_tap [4], b_long [4], b_held [4], b_lvl [4];

  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (press_pulse[i])   begin n_press[i]++; c_press[i] = cyc; end
      if (release_pulse[i]) begin n_rel[i]++;   c_rel[i]   = cyc; end
      if (tap_pulse[i])     begin n_tap[i]++;   c_tap[i]   = cyc; end
      if (long_pulse[i])    begin n_long[i]++;  c_long[i]  = cyc; end
      if (held_long[i]) n_held[i]++;
      if (level[i])     n_lvl[i]++;
    end
  end

  task automatic snap();
    for (int i = 0; i < NUM_CH; i++) begin
      b_press[i] = n_press[i]; b_rel[i] = n_rel[i]; b_tap[i] = n_tap[i];
      b_long[i]  = n_long[i];  b_held[i] = n_held[i]; b_lvl[i] = n_lvl[i];
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press channel ch for n clks (n/DIV samples), then release and settle.
  task automatic press_for(input int ch, input int n);
    @(negedge clk);
    btn_in[ch] = ~MASK[ch];
    clocks(n);
    btn_in[ch] = MASK[ch];
    clocks(40);
  endtask

  int rst_cyc;

  initial begin
    #2 rst = 1'b1;
    clocks(3);
    rst = 1'b0;
    clocks(20);
    chk("reset_outputs", level | press_pulse | release_pulse | tap_pulse | long_pulse | held_long, 4'b0000);
    chk_int("reset_no_press", n_press[0] + n_press[1] + n_press[2] + n_press[3], 0);

    // 1: short press on ch0 -> tap
    snap();
    press_for(0, 16);
    chk_int("s1_press", n_press[0] - b_press[0], 1);
    chk_int("s1_release", n_rel[0] - b_rel[0], 1);
    chk_int("s1_tap", n_tap[0] - b_tap[0], 1);
    chk_int("s1_long", n_long[0] - b_long[0], 0);
    chk_int("s1_tap_with_release", c_tap[0], c_rel[0]);

    // 2: ch1 held 10 ticks -> long, no tap
    snap();
    press_for(1, 40);
    chk_int("s2_long", n_long[1] - b_long[1], 1);
    chk_int("s2_long_delay", c_long[1] - c_press[1], LONG_T * DIV);
    chk_int("s2_held_clks", n_held[1] - b_held[1], 20);
    chk_int("s2_release", n_rel[1] - b_rel[1], 1);
    chk_int("s2_tap", n_tap[1] - b_tap[1], 0);

    // 3: ch2 with 2-sample glitches -> nothing
    snap();
    for (int j = 0; j < 10; j++) begin
      btn_in[2] = 1'b1; clocks(8);
      btn_in[2] = 1'b0; clocks(8);
    end
    clocks(20);
    chk_int("s3_level", n_lvl[2] - b_lvl[2], 0);
    chk_int("s3_press", n_press[2] - b_press[2], 0);

    // 4: ch0 and active-low ch3 pressed together
    snap();
    @(negedge clk);
    btn_in[0] = 1'b1; btn_in[3] = 1'b0;
    clocks(16);
    btn_in[0] = 1'b0; btn_in[3] = 1'b1;
    clocks(40);
    chk_int("s4_press_ch0", n_press[0] - b_press[0], 1);
    chk_int("s4_press_ch3", n_press[3] - b_press[3], 1);
    chk_int("s4_same_clk", c_press[3], c_press[0]);
    chk_int("s4_tap_ch3", n_tap[3] - b_tap[3], 1);

    // 5: reset mid-hold on ch1, button still held afterwards
    snap();
    @(negedge clk);
    btn_in[1] = 1'b1;
    clocks(28);
    chk("s5_level_before_rst", level, 4'b0010);
    #1 rst = 1'b1;
    #1 chk("s5_async_clear", level | held_long | press_pulse | release_pulse | tap_pulse | long_pulse, 4'b0000);
    clocks(2);
    rst = 1'b0;
    rst_cyc = cyc;
    chk_int("s5_no_release", n_rel[1] - b_rel[1], 0);
    clocks(20);
    chk_int("s5_repress_delay", c_press[1] - rst_cyc, DEB * DIV + 1);
    chk_int("s5_press_count", n_press[1] - b_press[1], 2);
    btn_in[1] = 1'b0;
    clocks(40);

    // 6: ch0 held 12 ticks, then 11 ticks (release lands on a repeat tick)
    snap();
    press_for(0, 48);
    chk_int("s6_press_12", n_press[0] - b_press[0], AUTO_REP ? 4 : 1);
    chk_int("s6_long_12", n_long[0] - b_long[0], 1);
    chk_int("s6_tap_12", n_tap[0] - b_tap[0], 0);
    snap();
    press_for(0, 44);
    chk_int("s6_press_11", n_press[0] - b_press[0], AUTO_REP ? 3 : 1);

    // 7: release on the same tick the hold reaches LONG_TICKS -> tap wins
    snap();
    press_for(2, 20);
    chk_int("s7_tap", n_tap[2] - b_tap[2], 1);
    chk_int("s7_long", n_long[2] - b_long[2], 0);
    chk_int("s7_held", n_held[2] - b_held[2], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
